regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//   Parametrised successor to the 8x8 datapath register file: 2 combinational read ports,
//   1 write port, optional write-to-read bypass, optional hardwired zero register, and an
//   NFLAGS-bit condition-flag register with per-bit write enables. A clear engine zeroes
//   every entry sequentially after reset or on request. Sits between decode and the ALU.
// PARAMETERS
//   DATA_W    8   data width of each entry
//   ADDR_W    3   address width; DEPTH = 2**ADDR_W entries
//   NFLAGS    1   number of condition-flag bits
//   ZERO_REG  0   1: entry 0 always reads 0 and ignores writes
//   BYPASS    1   1: a same-cycle write forwards to a matching read port
// PORTS
//   clk_i         in   1       clock; all state updates on rising edge
//   reset_ni      in   1       asynchronous, active-low reset
//   clear_i       in   1       request a full sequential clear (sampled in READY only)
//   ready_o       out  1       1 = READY state; reads and writes valid
//   write_i       in   1       register write enable
//   write_addr_i  in   ADDR_W  write address
//   write_data_i  in   DATA_W  write data
//   rs_addr_i     in   ADDR_W  read port S address
//   rs_data_o     out  DATA_W  read port S data (combinational)
//   rt_addr_i     in   ADDR_W  read port T address
//   rt_data_o     out  DATA_W  read port T data (combinational)
//   flag_we_i     in   NFLAGS  per-bit flag write enable
//   flag_data_i   in   NFLAGS  flag write data
//   flag_o        out  NFLAGS  registered flag value
// BEHAVIOUR
//   - FSM states: CLEAR, READY. reset_ni low: state=CLEAR, clr_ptr=0, flag_o=0, ready_o=0.
//   - CLEAR: each edge writes 0 to entry clr_ptr, then clr_ptr++. At the edge that clears
//     entry DEPTH-1, state goes to READY. ready_o rises DEPTH edges after reset release.
//   - In CLEAR: write_i, flag_we_i and clear_i are ignored; rs_data_o and rt_data_o read 0.
//   - READY: when write_i=1, mem[write_addr_i] <= write_data_i at the edge.
//     Flag bit i <= flag_data_i[i] when flag_we_i[i]=1; other flag bits hold.
//   - READY with clear_i=1: go to CLEAR with clr_ptr=0, and clear flag_o at that same edge.
//     clear_i wins over a simultaneous write_i or flag_we_i; both of those are discarded.
//   - Reads: rX_data_o = mem[rX_addr_i], combinational, with 0 added latency.
//   - BYPASS=1 in READY: when write_i=1 and write_addr_i==rX_addr_i, rX_data_o=write_data_i.
//     BYPASS=0: the read returns the old value until the next edge.
//   - ZERO_REG=1: address 0 reads 0 on both ports, writes to it are dropped, and it never
//     bypasses. The clear engine still steps through all DEPTH entries.
//   - flag_o has no bypass; a new value is visible one cycle after the write.
//   - reset_ni asserted mid-CLEAR or mid-operation restarts the clear from entry 0.
//   - Both read ports may address the same entry; both return the same value.
// TESTING
//   1 Reset release with defaults -> ready_o=0 for 8 edges, 1 after; every address reads 0.
//   2 Write 0xA5 to r3 while rs=3, BYPASS=1 -> rs_data_o=0xA5 the same cycle.
//     Same with BYPASS=0 -> reads 0x00, then 0xA5 after the edge.
//   3 ZERO_REG=1: write 0xFF to r0, rs=rt=0 -> both ports read 0x00 before and after.
//   4 NFLAGS=4, flags=4'b1010, flag_we=4'b0011, flag_data=4'b0101 -> flag_o=4'b1001 next cycle.
//   5 clear_i together with write r5=0x3C in READY -> write dropped, ready_o=0 for 8 cycles,
//     then r5 reads 0x00 and flag_o=0.
//   6 Assert reset_ni at clr_ptr=4 -> outputs reset at once; after release, 8 full clear cycles.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with two combinational read ports,
// one write port, optional write-to-read bypass, optional hardwired zero entry,
// a per-bit-enabled condition-flag register and a sequential clear engine.
module regfile_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NFLAGS   = 1,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              clear_i,
    output logic              ready_o,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] write_addr_i,
    input  logic [DATA_W-1:0] write_data_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rt_data_o,
    input  logic [NFLAGS-1:0] flag_we_i,
    input  logic [NFLAGS-1:0] flag_data_i,
    output logic [NFLAGS-1:0] flag_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_ptr_q;
    logic [NFLAGS-1:0]   flag_q;
    logic [NFLAGS-1:0]   flag_d;
    logic                ready_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_zero_c;
    logic                wr_fire_c;
    logic                mem_we_c;
    logic [ADDR_W-1:0]   mem_waddr_c;
    logic [DATA_W-1:0]   mem_wdata_c;

    // A user write is effective only in READY, without a competing clear, and not to a hardwired zero entry
    always_comb begin
        wr_zero_c = (ZERO_REG != 0) && (write_addr_i == '0);
        wr_fire_c = (state_q == ST_READY) && write_i && !clear_i && !wr_zero_c;
    end

    // Next flag value: enabled bits take new data, the rest hold
    always_comb begin
        flag_d = (flag_q & ~flag_we_i) | (flag_data_i & flag_we_i);
    end

    // Control FSM: clear engine sweep, READY handshake and flag register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            flag_q    <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
                    if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (clear_i) begin
                        state_q   <= ST_CLEAR;
                        clr_ptr_q <= '0;
                        flag_q    <= '0;
                        ready_q   <= 1'b0;
                    end else begin
                        flag_q <= flag_d;
                    end
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_ptr_q <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    // Memory write port mux: the clear engine owns the port while clearing
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = write_addr_i;
        mem_wdata_c = write_data_i;
        if (state_q == ST_CLEAR) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = clr_ptr_q;
            mem_wdata_c = '0;
        end else if (wr_fire_c) begin
            mem_we_c = 1'b1;
        end
    end

    // Storage array; contents are initialised by the clear engine, not by reset
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // One read port: zero while clearing or for the hardwired entry, else bypass or stored value
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (state_q == ST_READY) begin
            if ((ZERO_REG != 0) && (addr == '0)) begin
                val = '0;
            end else if ((BYPASS != 0) && wr_fire_c && (write_addr_i == addr)) begin
                val = write_data_i;
            end else begin
                val = mem_q[addr];
            end
        end
        return val;
    endfunction

    // Combinational read ports
    always_comb begin
        rs_data_o = read_port(rs_addr_i);
        rt_data_o = read_port(rt_addr_i);
    end

    assign ready_o = ready_q;
    assign flag_o  = flag_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (bypassing 4-flag file, and non-bypassing
// zero-register 1-flag file) driven with shared stimulus.
module tb_regfile_param;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       write;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [3:0] fwe;
    logic [3:0] fd;

    logic       a_ready, b_ready;
    logic [7:0] a_rs, a_rt, b_rs, b_rt;
    logic [3:0] a_flag;
    logic [0:0] b_flag;

    int checks   = 0;
    int failures = 0;

    regfile_param #(.DATA_W(8), .ADDR_W(3), .NFLAGS(4), .ZERO_REG(0), .BYPASS(1)) u_a (
        .clk_i(clk), .reset_ni(rst_n), .clear_i(clear), .ready_o(a_ready),
        .write_i(write), .write_addr_i(waddr), .write_data_i(wdata),
        .rs_addr_i(rs), .rs_data_o(a_rs), .rt_addr_i(rt), .rt_data_o(a_rt),
        .flag_we_i(fwe), .flag_data_i(fd), .flag_o(a_flag)
    );

    regfile_param #(.DATA_W(8), .ADDR_W(3), .NFLAGS(1), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk_i(clk), .reset_ni(rst_n), .clear_i(clear), .ready_o(b_ready),
        .write_i(write), .write_addr_i(waddr), .write_data_i(wdata),
        .rs_addr_i(rs), .rs_data_o(b_rs), .rt_addr_i(rt), .rt_data_o(b_rt),
        .flag_we_i(fwe[0:0]), .flag_data_i(fd[0:0]), .flag_o(b_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: entries still to be cleared, contents and flags
    int         clr_left;
    logic [7:0] ma [8];
    logic [7:0] mb [8];
    logic [3:0] fa;
    logic       fb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_a(input logic [2:0] a);
        if (clr_left != 0) return 8'h00;
        if (write && !clear && waddr == a) return wdata;
        return ma[a];
    endfunction

    function automatic logic [7:0] exp_b(input logic [2:0] a);
        if (clr_left != 0) return 8'h00;
        if (a == 3'd0) return 8'h00;
        return mb[a];
    endfunction

    task automatic model_reset();
        clr_left = 8;
        fa = 4'h0;
        fb = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        if (clr_left != 0) begin
            ma[8 - clr_left] = 8'h00;
            mb[8 - clr_left] = 8'h00;
            clr_left--;
        end else if (clear) begin
            clr_left = 8;
            fa = 4'h0;
            fb = 1'b0;
        end else begin
            if (write) ma[waddr] = wdata;
            if (write && waddr != 3'd0) mb[waddr] = wdata;
            fa = (fa & ~fwe) | (fd & fwe);
            if (fwe[0]) fb = fd[0];
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a_ready"}, 32'(a_ready), 32'(clr_left == 0));
        chk({tag, ".b_ready"}, 32'(b_ready), 32'(clr_left == 0));
        chk({tag, ".a_rs"}, 32'(a_rs), 32'(exp_a(rs)));
        chk({tag, ".a_rt"}, 32'(a_rt), 32'(exp_a(rt)));
        chk({tag, ".b_rs"}, 32'(b_rs), 32'(exp_b(rs)));
        chk({tag, ".b_rt"}, 32'(b_rt), 32'(exp_b(rt)));
        chk({tag, ".a_flag"}, 32'(a_flag), 32'(fa));
        chk({tag, ".b_flag"}, 32'(b_flag), 32'(fb));
    endtask

    // Advance one rising edge, updating the model, then step off the edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        clear = 1'b0; write = 1'b0; waddr = 3'd0; wdata = 8'h00;
        fwe = 4'h0; fd = 4'h0;
    endtask

    // From a negedge just after reset release: ready low before each of 8 edges, high after
    task automatic count_clear(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk({tag, ".ready_low"}, 32'(a_ready | b_ready), 32'd0);
            chk({tag, ".read_zero"}, 32'(a_rs | a_rt | b_rs | b_rt), 32'd0);
            tick();
            @(negedge clk);
        end
        chk({tag, ".a_ready_high"}, 32'(a_ready), 32'd1);
        chk({tag, ".b_ready_high"}, 32'(b_ready), 32'd1);
    endtask

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [3:0] fwe;
        logic [3:0] fd;
        logic [7:0] a_rs;
        logic [7:0] a_rt;
        logic [3:0] a_fl;
        logic [7:0] b_rs;
        logic [7:0] b_rt;
        logic       b_fl;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd0, 4'h0, 4'h0, 8'hA5, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 4'hA, 4'hA, 8'hA5, 8'hA5, 4'h0, 8'hA5, 8'hA5, 1'b0};
        tbl[2] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 4'h3, 4'h5, 8'hFF, 8'hFF, 4'hA, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd3, 4'h0, 4'h0, 8'hFF, 8'hA5, 4'h9, 8'h00, 8'hA5, 1'b1};
        tbl[4] = '{1'b1, 3'd7, 8'h5A, 3'd7, 3'd7, 4'hF, 4'h0, 8'h5A, 8'h5A, 4'h9, 8'h00, 8'h00, 1'b1};
        tbl[5] = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd0, 4'h0, 4'h0, 8'h5A, 8'hFF, 4'h0, 8'h5A, 8'h00, 1'b0};

        // Reset state and first clear sweep
        rst_n = 1'b0;
        idle_inputs();
        rs = 3'd0; rt = 3'd0;
        model_reset();
        #12;
        chk("reset.ready", 32'(a_ready | b_ready), 32'd0);
        chk("reset.a_flag", 32'(a_flag), 32'd0);
        chk("reset.b_flag", 32'(b_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_clear("init");
        for (int a = 0; a < 8; a++) begin
            rs = 3'(a); rt = 3'(7 - a);
            #1;
            chk("init.a_rs_zero", 32'(a_rs), 32'd0);
            chk("init.a_rt_zero", 32'(a_rt), 32'd0);
            chk("init.b_rs_zero", 32'(b_rs), 32'd0);
        end
        tick();

        // Directed vectors: bypass, no-bypass, zero register, per-bit flag enables
        for (int i = 0; i < 6; i++) begin
            write = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd;
            rs = tbl[i].rs; rt = tbl[i].rt; fwe = tbl[i].fwe; fd = tbl[i].fd;
            @(negedge clk);
            chk($sformatf("vec%0d.a_rs", i), 32'(a_rs), 32'(tbl[i].a_rs));
            chk($sformatf("vec%0d.a_rt", i), 32'(a_rt), 32'(tbl[i].a_rt));
            chk($sformatf("vec%0d.a_flag", i), 32'(a_flag), 32'(tbl[i].a_fl));
            chk($sformatf("vec%0d.b_rs", i), 32'(b_rs), 32'(tbl[i].b_rs));
            chk($sformatf("vec%0d.b_rt", i), 32'(b_rt), 32'(tbl[i].b_rt));
            chk($sformatf("vec%0d.b_flag", i), 32'(b_flag), 32'(tbl[i].b_fl));
            tick();
        end

        // clear_i wins over a simultaneous write; flags drop at the clear edge
        idle_inputs();
        fwe = 4'hF; fd = 4'hF;
        tick();
        idle_inputs();
        @(negedge clk);
        chk("clr.a_flag_set", 32'(a_flag), 32'hF);
        clear = 1'b1; write = 1'b1; waddr = 3'd5; wdata = 8'h3C;
        tick();
        idle_inputs();
        rs = 3'd5; rt = 3'd3;
        @(negedge clk);
        chk("clr.a_flag_zero", 32'(a_flag), 32'd0);
        chk("clr.b_flag_zero", 32'(b_flag), 32'd0);
        count_clear("clr");
        chk("clr.a_r5", 32'(a_rs), 32'd0);
        chk("clr.b_r5", 32'(b_rs), 32'd0);
        chk("clr.a_r3", 32'(a_rt), 32'd0);
        chk("clr.a_flag_after", 32'(a_flag), 32'd0);
        tick();

        // Reset mid-operation, then reset again at clr_ptr=4
        fwe = 4'hF; fd = 4'hF;
        tick();
        idle_inputs();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_op.ready", 32'(a_ready | b_ready), 32'd0);
        chk("rst_op.a_flag", 32'(a_flag), 32'd0);
        chk("rst_op.b_flag", 32'(b_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid.ready", 32'(a_ready | b_ready), 32'd0);
        chk("rst_mid.reads", 32'(a_rs | a_rt | b_rs | b_rt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_clear("rst_mid");
        tick();

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            write = 1'($urandom_range(0, 1));
            waddr = 3'($urandom);
            wdata = 8'($urandom);
            rs    = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom);
            rt    = ($urandom_range(0, 3) == 0) ? rs : 3'($urandom);
            fwe   = 4'($urandom);
            fd    = 4'($urandom);
            clear = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            check_all($sformatf("rnd%0d", n));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
